// File: rtl/logic_reduce.sv
// logic_reduce: streaming bitwise reduction (AND/OR/XOR/XNOR) across all beats
// of a packet, one registered result word per packet.
// Optional feature macro: LOGIC_REDUCE_BEATS_EN adds a saturating beat counter
// and the out_beats output port.
module logic_reduce #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       op_i,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef LOGIC_REDUCE_BEATS_EN
   output logic [CNT_W-1:0] out_beats,
`endif
   output logic [WIDTH-1:0] out_data
);

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [1:0]       r_op_q;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;

   logic             w_accept;
   logic             w_consume;
   logic             w_load;
   logic [1:0]       w_op;
   logic [WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0] w_final;

   // XOR and XNOR share the XOR accumulation; XNOR only inverts the final word.
   function automatic logic [WIDTH-1:0] f_combine(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] res;
      case (op)
         2'b00:   res = a & b;
         2'b01:   res = a | b;
         default: res = a ^ b;
      endcase
      return res;
   endfunction

   // A beat may enter whenever the output slot is free or being drained this cycle.
   assign in_ready  = !rst && (!r_out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_consume = r_out_valid && out_ready;
   assign w_load    = w_accept && in_last;

   // The op in force for this beat: live op_i on a packet's first beat, latched op after.
   assign w_op       = (r_state == S_IDLE) ? op_i : r_op_q;
   assign w_acc_next = (r_state == S_IDLE) ? in_data : f_combine(r_op_q, r_acc, in_data);
   assign w_final    = (w_op == 2'b11) ? ~w_acc_next : w_acc_next;

   // Packet FSM, accumulator and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_op_q      <= 2'b00;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_accept) begin
            r_acc <= w_acc_next;
            if (r_state == S_IDLE) begin
               r_op_q <= op_i;
            end
            r_state <= in_last ? S_IDLE : S_ACCUM;
         end
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_final;
         end else if (w_consume) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

`ifdef LOGIC_REDUCE_BEATS_EN
   localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_out_beats;
   logic [CNT_W-1:0] w_cnt_next;

   // Count including the current beat; restarts at 1 on a first beat, saturates at all-ones.
   assign w_cnt_next = (r_state == S_IDLE)  ? {{(CNT_W-1){1'b0}}, 1'b1} :
                       (r_cnt == LP_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

   // Beat counter, captured alongside the result word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_out_beats <= '0;
      end else begin
         if (w_accept) begin
            r_cnt <= w_cnt_next;
         end
         if (w_load) begin
            r_out_beats <= w_cnt_next;
         end
      end
   end

   assign out_beats = r_out_beats;
`else
   logic [CNT_W-1:0] w_unused_cnt;
   assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_reduce.sv
// Directed testbench for logic_reduce (WIDTH=8, CNT_W=2).
// Exercises out_beats when LOGIC_REDUCE_BEATS_EN is defined.
module tb_logic_reduce;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] op_i;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
`ifdef LOGIC_REDUCE_BEATS_EN
   logic [1:0] out_beats;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   logic_reduce #(.WIDTH(8), .CNT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_i      (op_i),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef LOGIC_REDUCE_BEATS_EN
      .out_beats (out_beats),
`endif
      .out_data  (out_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat for one cycle; it must be accepted.
   task automatic beat(input string tag, input logic [7:0] d, input logic l, input logic [1:0] op);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      op_i     = op;
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
   endtask

   // Drain the pending result and confirm the slot empties.
   task automatic consume(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      op_i      = 2'b00;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      // Reset state
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'h00);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef LOGIC_REDUCE_BEATS_EN
      check("rst_out_beats", {30'd0, out_beats}, 32'd0);
`endif
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // AND: F0 & 3C & FF = 30
      beat("and0", 8'hF0, 1'b0, 2'b00);
      beat("and1", 8'h3C, 1'b0, 2'b00);
      check("and_valid_before_last", {31'd0, out_valid}, 32'd0);
      beat("and2", 8'hFF, 1'b1, 2'b00);
      check("and_valid", {31'd0, out_valid}, 32'd1);
      check("and_data", {24'd0, out_data}, 32'h30);
`ifdef LOGIC_REDUCE_BEATS_EN
      check("and_beats", {30'd0, out_beats}, 32'd3);
`endif
      consume("and");

      // OR single beat
      beat("or0", 8'hA5, 1'b1, 2'b01);
      check("or_valid", {31'd0, out_valid}, 32'd1);
      check("or_data", {24'd0, out_data}, 32'hA5);
      consume("or");

      // XNOR: ~(0F ^ FF) = 0F, with idle gap mid-packet
      beat("xnor0", 8'h0F, 1'b0, 2'b11);
      step();
      step();
      check("xnor_gap_valid", {31'd0, out_valid}, 32'd0);
      beat("xnor1", 8'hFF, 1'b1, 2'b11);
      check("xnor_data", {24'd0, out_data}, 32'h0F);
      consume("xnor");

      // XOR: 0F ^ FF = F0
      beat("xor0", 8'h0F, 1'b0, 2'b10);
      beat("xor1", 8'hFF, 1'b1, 2'b10);
      check("xor_data", {24'd0, out_data}, 32'hF0);
      consume("xor");

      // Single-beat XNOR gives inverted input
      beat("xnor_s", 8'h3C, 1'b1, 2'b11);
      check("xnor_single_data", {24'd0, out_data}, 32'hC3);
      consume("xnor_s");

      // Op latched on first beat: AND kept despite op_i=OR later
      beat("latch0", 8'hFF, 1'b0, 2'b00);
      beat("latch1", 8'h0F, 1'b1, 2'b01);
      check("latch_data", {24'd0, out_data}, 32'h0F);

      // Backpressure: result held, input blocked
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_data", {24'd0, out_data}, 32'h0F);
         step();
      end
      // Consume and load in the same cycle
      out_ready = 1'b1;
      #1;
      beat("bp_new", 8'h81, 1'b1, 2'b01);
      check("bp_new_valid", {31'd0, out_valid}, 32'd1);
      check("bp_new_data", {24'd0, out_data}, 32'h81);
      step();
      check("bp_new_drained", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;

      // Reset mid-packet discards partial accumulation
      beat("mid0", 8'h00, 1'b0, 2'b00);
      beat("mid1", 8'hFF, 1'b0, 2'b00);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_in_ready2", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      beat("mid_new", 8'hFF, 1'b1, 2'b00);
      check("mid_new_valid", {31'd0, out_valid}, 32'd1);
      check("mid_new_data", {24'd0, out_data}, 32'hFF);
      consume("mid_new");

      // Long packet: beat count saturates at 3 for CNT_W=2
      for (int i = 0; i < 4; i++) begin
         beat("long", 8'hFF, 1'b0, 2'b00);
      end
      beat("long_last", 8'hFF, 1'b1, 2'b00);
      check("long_data", {24'd0, out_data}, 32'hFF);
`ifdef LOGIC_REDUCE_BEATS_EN
      check("long_beats", {30'd0, out_beats}, 32'd3);
`endif
      consume("long");

      // Two-beat packet
      beat("two0", 8'h12, 1'b0, 2'b01);
      beat("two1", 8'h40, 1'b1, 2'b01);
      check("two_data", {24'd0, out_data}, 32'h52);
`ifdef LOGIC_REDUCE_BEATS_EN
      check("two_beats", {30'd0, out_beats}, 32'd2);
`endif
      consume("two");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/logic_reduce.md
Name: logic_reduce

Overview:
- Parametrised streaming successor to the single-bit and_m/or_m gates.
- Accepts packets of WIDTH-bit words over a valid/ready input, applies a selectable bitwise op (AND/OR/XOR/XNOR) across every beat of a packet, and emits one registered result word per packet over a valid/ready output.
- Used wherever a datapath needs a bitwise mask/parity summary of a burst.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CNT_W, 8, beat-counter width; used only when LOGIC_REDUCE_BEATS_EN is defined.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- op_i  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 XNOR; sampled on first beat of a packet only.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  input word.
- in_last  input  1  marks final beat of packet.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  packet result.
- out_beats  output  CNT_W  beats in packet (present only with LOGIC_REDUCE_BEATS_EN).

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, acc=0, op_q=00, out_valid=0, out_data=0, out_beats=0.
  - in_ready=0 while rst=1.
- Handshakes:
  - Beat accepted when in_valid&in_ready.
  - Result consumed when out_valid&out_ready.
- in_ready = !rst & (!out_valid | out_ready), combinational.
  - One accumulator plus one output register; non-final beats are also blocked while the output is held. This keeps the rule simple.
- States: IDLE (no packet open), ACCUM (packet open).
- IDLE, beat accepted:
  - acc<=in_data; op_q<=op_i.
  - in_last=0 -> ACCUM.
  - in_last=1 -> load output, stay IDLE.
- ACCUM, beat accepted:
  - acc<=acc OP in_data, with OP from op_q. XOR and XNOR both accumulate with XOR.
  - in_last=1 -> load output, go to IDLE.
- op_i is ignored outside the first beat. Changes mid-packet have no effect.
- Load output:
  - out_data<=final, where final is the accumulated value including the current beat, inverted when op_q=11 (XNOR).
  - out_valid<=1.
- Latency: out_valid rises the cycle after the last beat is accepted. A single-beat packet gives in_data, or ~in_data for XNOR.
- out_valid clears when consumed and no load occurs that cycle.
- Simultaneous consume and load: out_valid stays 1 and out_data takes the new result. No bubble, no lost result.
- out_data/out_valid hold stable while out_valid=1 & out_ready=0.
- in_valid=0 in ACCUM: state and acc hold indefinitely; no timeout.
- Reset mid-packet: the partial packet is discarded, any pending result is dropped, and the next accepted beat starts a new packet.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro LOGIC_REDUCE_BEATS_EN.
- Defined:
  - out_beats port exists.
  - Internal counter set to 1 on the first beat, incremented per accepted beat, saturating at 2^CNT_W-1.
  - Loaded into out_beats with out_data; held with it under backpressure.
- Undefined: no counter, no out_beats port; all other behaviour identical.

Test Plan:
- AND: op=00, beats 0xF0, 0x3C, 0xFF(last) -> out_data=0x30, out_valid=1 exactly one cycle after the last handshake. OR single beat 0xA5(last) -> 0xA5.
- XNOR: op=11, beats 0x0F, 0xFF(last) -> out_data=0x0F. XOR same beats -> 0xF0.
- Op latching: op=00 on beat 0xFF, op_i switched to 01 before beat 0x0F(last) -> out_data=0x0F (AND kept).
- Backpressure: hold out_ready=0 after a result -> in_ready=0, out_data stable for 5 cycles. Then present the next single-beat packet 0x81 (OR) with out_ready=1 -> consume and load in the same cycle, out_valid stays 1, out_data=0x81 next cycle.
- Reset mid-packet: two AND beats 0x00, 0xFF, then rst for 1 cycle -> out_valid=0, in_ready=0 during reset. New packet 0xFF(last) with op=00 -> 0xFF, with no carry-over of 0x00.
- LOGIC_REDUCE_BEATS_EN, CNT_W=2: 5-beat packet -> out_beats=3 (saturated); 2-beat packet -> out_beats=2. Build without the macro and rerun the first scenario -> identical out_data.
